// File: rtl/game_control.sv
// game_control: per-frame phase sequencer for the game datapath.
//
// This block is the only driver of the datapath phase enables. Each frame
// runs through the phases in a fixed order and waits on the datapath done
// handshakes. Every draw phase is bounded by a watchdog.
//
// State table:
//   state       | meaning
//   S_INIT      | datapath init, held INIT_CYCLES cycles after reset release
//   S_IDLE      | wait for the frame-rate tick (idle_done)
//   S_GEN       | register user/enemy actions, 1 cycle
//   S_COLL      | collision calculation, COLLIDE_CYCLES cycles
//   S_APPLY     | apply link action, 1 cycle
//   S_MOVE_EN   | apply enemy movement, 1 cycle
//   S_DRAW_MAP  | map draw, until draw_map_done or watchdog expiry
//   S_DRAW_LINK | link draw, until draw_link_done or watchdog expiry
//   S_DRAW_EN   | enemy draw, until draw_enemies_done or watchdog expiry
//
// Ports:
//   clock, reset           system clock, async active-high reset
//   pause                  sampled on the idle exit cycle; paused frames only redraw
//   idle_done              frame-rate tick from the datapath
//   draw_*_done            draw completion handshakes
//   init .. draw_enemies   one-hot phase enables (Moore decode, 0 in reset)
//   frame_count            completed frames since init, wraps
//   timeout_err            sticky, a draw phase hit DRAW_TIMEOUT
module game_control #(
  parameter int unsigned INIT_CYCLES    = 4,
  parameter int unsigned COLLIDE_CYCLES = 2,
  parameter int unsigned MAP_PERIOD     = 1,
  parameter logic [16:0] DRAW_TIMEOUT   = 17'd100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pause,
  input  logic        idle_done,
  input  logic        draw_map_done,
  input  logic        draw_link_done,
  input  logic        draw_enemies_done,
  output logic        init,
  output logic        idle,
  output logic        gen_move,
  output logic        check_collide,
  output logic        apply_act_link,
  output logic        move_enemies,
  output logic        draw_map,
  output logic        draw_link,
  output logic        draw_enemies,
  output logic [15:0] frame_count,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_GEN,
    S_COLL,
    S_APPLY,
    S_MOVE_EN,
    S_DRAW_MAP,
    S_DRAW_LINK,
    S_DRAW_EN
  } state_t;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] COLL_LAST = 16'(COLLIDE_CYCLES - 1);
  localparam logic [7:0]  MAP_LAST  = 8'(MAP_PERIOD - 1);
  localparam logic [16:0] WD_LAST   = DRAW_TIMEOUT - 17'd1;

  state_t      state, state_next;
  logic [15:0] phase_cnt;
  logic [16:0] watchdog;
  logic [7:0]  map_div;

  logic        in_draw;
  logic        cur_done;
  logic        wd_expired;
  logic        draw_exit;
  logic        timeout_hit;
  logic        frame_end;
  state_t      draw_target;

  // Done and in-draw qualifiers for the current state; done inputs are only
  // looked at in their own state, so stale levels are ignored elsewhere.
  always_comb begin
    in_draw  = 1'b0;
    cur_done = 1'b0;
    case (state)
      S_DRAW_MAP:  begin in_draw = 1'b1; cur_done = draw_map_done;     end
      S_DRAW_LINK: begin in_draw = 1'b1; cur_done = draw_link_done;    end
      S_DRAW_EN:   begin in_draw = 1'b1; cur_done = draw_enemies_done; end
      default:     begin in_draw = 1'b0; cur_done = 1'b0;              end
    endcase
  end

  assign wd_expired  = (watchdog == WD_LAST);
  assign draw_exit   = in_draw && (cur_done || wd_expired);
  // A done on the expiry cycle wins: no error is flagged.
  assign timeout_hit = in_draw && !cur_done && wd_expired;
  assign frame_end   = (state == S_DRAW_EN) && draw_exit;
  assign draw_target = (map_div == 8'd0) ? S_DRAW_MAP : S_DRAW_LINK;

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:      if (phase_cnt == INIT_LAST) state_next = S_IDLE;
      S_IDLE:      if (idle_done) state_next = pause ? draw_target : S_GEN;
      S_GEN:       state_next = S_COLL;
      S_COLL:      if (phase_cnt == COLL_LAST) state_next = S_APPLY;
      S_APPLY:     state_next = S_MOVE_EN;
      S_MOVE_EN:   state_next = draw_target;
      S_DRAW_MAP:  if (draw_exit) state_next = S_DRAW_LINK;
      S_DRAW_LINK: if (draw_exit) state_next = S_DRAW_EN;
      S_DRAW_EN:   if (draw_exit) state_next = S_IDLE;
      default:     state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_INIT;
      phase_cnt   <= 16'd0;
      watchdog    <= 17'd0;
      map_div     <= 8'd0;
      frame_count <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;

      // Phase counter restarts on every state change.
      if (state_next != state) phase_cnt <= 16'd0;
      else                     phase_cnt <= phase_cnt + 16'd1;

      // Watchdog only runs while sitting in a draw state.
      if ((state_next != state) || !in_draw) watchdog <= 17'd0;
      else                                   watchdog <= watchdog + 17'd1;

      if (state == S_INIT) begin
        frame_count <= 16'd0;
        map_div     <= 8'd0;
      end else if (frame_end) begin
        frame_count <= frame_count + 16'd1;
        map_div     <= (map_div == MAP_LAST) ? 8'd0 : map_div + 8'd1;
      end

      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  // Enables are forced low while reset is held so they drop without waiting
  // for a clock edge.
  always_comb begin
    init           = 1'b0;
    idle           = 1'b0;
    gen_move       = 1'b0;
    check_collide  = 1'b0;
    apply_act_link = 1'b0;
    move_enemies   = 1'b0;
    draw_map       = 1'b0;
    draw_link      = 1'b0;
    draw_enemies   = 1'b0;
    if (!reset) begin
      case (state)
        S_INIT:      init           = 1'b1;
        S_IDLE:      idle           = 1'b1;
        S_GEN:       gen_move       = 1'b1;
        S_COLL:      check_collide  = 1'b1;
        S_APPLY:     apply_act_link = 1'b1;
        S_MOVE_EN:   move_enemies   = 1'b1;
        S_DRAW_MAP:  draw_map       = 1'b1;
        S_DRAW_LINK: draw_link      = 1'b1;
        S_DRAW_EN:   draw_enemies   = 1'b1;
        default:     init           = 1'b0;
      endcase
    end
  end

endmodule
